// File: rtl/cla_nibble_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder controller driving one shared external 4-bit CLA.
// Start/ready/done handshake; one nibble per clock, LSB first, carry chained through carry_r.
module cla_nibble_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_c3
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // Nibble select via constant-index loop keeps part-select widths exact for any WIDTH.
  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      cla_cin = carry_r;
      for (int unsigned i = 0; i < NIB; i++) begin
        if (idx == IW'(i)) begin
          cla_a = a_r[4*i +: 4];
          cla_b = b_r[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            state   <= RUN;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum[4*i +: 4] <= cla_s;
          end
          carry_r <= cla_c3;
          if (idx == LAST) begin
            cout  <= cla_c3;
            idx   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
